// File: rtl/square_result_collector_if.sv
// Issue and result handshake bundle for square_result_collector.
// slave = collector side, master = issuing logic plus result consumer.
interface square_result_collector_if #(
  parameter int WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   radicand;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_radicand;
  logic [WIDTH-1:0]     out_root;
  logic [2*WIDTH-1:0]   out_remainder;
  logic [WIDTH:0]       out_round;
  logic                 out_err;

  modport slave (
    input  in_valid, radicand, out_ready,
    output in_ready, out_valid, out_radicand,
    output out_root, out_remainder, out_round,
    output out_err
  );

  modport master (
    output in_valid, radicand, out_ready,
    input  in_ready, out_valid, out_radicand,
    input  out_root, out_remainder, out_round,
    input  out_err
  );
endinterface

// File: rtl/square_result_collector.sv
// Collects sqrt extractor results, checks them, adds rounding, FWFT FIFO.
// Ports: clk, rst_n (sync low), sq_dout/sq_remainder, err_count, bus.
module square_result_collector #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = WIDTH,
  parameter int DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     sq_dout,
  input  logic [2*WIDTH-1:0]   sq_remainder,
  output logic [7:0]           err_count,
  square_result_collector_if.slave bus
);
  localparam int RW = 2 * WIDTH;
  localparam int SW = RW + 1;
  localparam int WW = WIDTH + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(DEPTH + LATENCY + 1);

  logic [LATENCY-1:0] dl_vld;
  logic [RW-1:0]      dl_rad [LATENCY];
  logic [CW-1:0]      inflight;
  logic [FW-1:0]      fifo_count;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               accept;
  logic               push;
  logic               pop;

  logic [SW-1:0]      d_ext;
  logic [SW-1:0]      sum;
  logic [SW-1:0]      twice;
  logic               chk_err;
  logic               rnd_up;
  logic [WW-1:0]      rnd;

  logic [RW-1:0]      m_rad  [DEPTH];
  logic [WIDTH-1:0]   m_root [DEPTH];
  logic [RW-1:0]      m_rem  [DEPTH];
  logic [WW-1:0]      m_rnd  [DEPTH];
  logic [DEPTH-1:0]   m_err;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++)
      inflight = inflight + CW'(dl_vld[i]);
  end

  // Credit counts both queued and in-flight results.
  assign bus.in_ready =
    (CW'(fifo_count) + inflight) < CW'(DEPTH);
  assign accept = bus.in_valid & bus.in_ready;
  assign push   = dl_vld[LATENCY-1];
  assign pop    = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n)
      dl_vld <= '0;
    else
      dl_vld <= {dl_vld[LATENCY-2:0], accept};
  end

  always_ff @(posedge clk) begin
    dl_rad[0] <= bus.radicand;
    for (int i = 1; i < LATENCY; i++)
      dl_rad[i] <= dl_rad[i-1];
  end

  // Widened to 2*WIDTH+1 so root^2 + rem never wraps.
  always_comb begin
    d_ext   = SW'(sq_dout);
    sum     = d_ext * d_ext + SW'(sq_remainder);
    twice   = d_ext << 1;
    chk_err = (sum != SW'(dl_rad[LATENCY-1]))
            | (SW'(sq_remainder) > twice);
    rnd_up  = sq_remainder > RW'(sq_dout);
    rnd     = WW'(sq_dout) + WW'(rnd_up);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      m_rad[wr_ptr]  <= dl_rad[LATENCY-1];
      m_root[wr_ptr] <= sq_dout;
      m_rem[wr_ptr]  <= sq_remainder;
      m_rnd[wr_ptr]  <= rnd;
      m_err[wr_ptr]  <= chk_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      err_count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FW'(1);
        2'b01:   fifo_count <= fifo_count - FW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && chk_err && err_count != 8'hff)
        err_count <= err_count + 8'd1;
    end
  end

  assign bus.out_valid = fifo_count != '0;

  // Head fields are zeroed when empty so reset leaves clean outputs.
  always_comb begin
    bus.out_radicand  = '0;
    bus.out_root      = '0;
    bus.out_remainder = '0;
    bus.out_round     = '0;
    bus.out_err       = 1'b0;
    if (bus.out_valid) begin
      bus.out_radicand  = m_rad[rd_ptr];
      bus.out_root      = m_root[rd_ptr];
      bus.out_remainder = m_rem[rd_ptr];
      bus.out_round     = m_rnd[rd_ptr];
      bus.out_err       = m_err[rd_ptr];
    end
  end
endmodule

// File: tb/tb_square_result_collector.sv
// Randomized bench for square_result_collector with a queue-based model.
// Includes a behavioural fixed-latency sqrt extractor with fault injection.
module tb_square_result_collector;
  localparam int W = 4;
  localparam int L = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] sq_dout;
  logic [7:0]   sq_remainder;
  logic [7:0]   err_count;
  bit           flt;

  square_result_collector_if #(.WIDTH(W)) bus ();

  square_result_collector #(
    .WIDTH(W), .LATENCY(L), .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sq_dout(sq_dout),
    .sq_remainder(sq_remainder),
    .err_count(err_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int isqrt(input int v);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= v)
      r++;
    return r;
  endfunction

  int xp_rad [L];
  bit xp_flt [L];
  int x_t;
  int x_rt;

  always @(posedge clk) begin
    xp_rad[0] <= int'(bus.radicand);
    xp_flt[0] <= flt;
    for (int i = 1; i < L; i++) begin
      xp_rad[i] <= xp_rad[i-1];
      xp_flt[i] <= xp_flt[i-1];
    end
  end

  always_comb begin
    x_t          = xp_rad[L-1];
    x_rt         = isqrt(x_t);
    sq_dout      = W'(x_rt);
    sq_remainder = 8'(x_t - x_rt * x_rt + int'(xp_flt[L-1]));
  end

  typedef struct {
    int rad;
    int root;
    int rem;
    int rnd;
    bit err;
    int avail;
  } ent_t;

  ent_t mq[$];
  int   m_err;
  int   cyc;
  int   n_chk;
  int   n_fail;
  bit   last_acc;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d",
               tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit v, input int r,
                      input bit f, input bit ordy,
                      input bit rst);
    bit   m_rdy;
    bit   m_vld;
    bit   acc;
    bit   pop;
    ent_t e;
    int   rm;
    bus.in_valid  = v;
    bus.radicand  = 8'(r);
    flt           = f;
    bus.out_ready = ordy;
    rst_n         = rst;
    #1;
    m_rdy = mq.size() < D;
    m_vld = mq.size() > 0 && mq[0].avail <= cyc;
    chk("in_ready", bus.in_ready, m_rdy);
    chk("out_valid", bus.out_valid, m_vld);
    chk("err_count", err_count, m_err);
    if (m_vld) begin
      chk("radicand", bus.out_radicand, mq[0].rad);
      chk("root", bus.out_root, mq[0].root);
      chk("remainder", bus.out_remainder, mq[0].rem);
      chk("round", bus.out_round, mq[0].rnd);
      chk("err", bus.out_err, mq[0].err);
    end
    acc = v & m_rdy & rst;
    pop = m_vld & ordy & rst;
    last_acc = acc;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      mq.delete();
      m_err = 0;
    end else begin
      if (pop)
        void'(mq.pop_front());
      if (acc) begin
        e.rad   = r & 255;
        e.root  = isqrt(e.rad);
        rm      = e.rad - e.root * e.root + int'(f);
        e.rem   = rm;
        e.rnd   = (rm > e.root) ? e.root + 1 : e.root;
        e.err   = (e.root * e.root + rm != e.rad)
               || (rm > 2 * e.root);
        e.avail = cyc + L;
        mq.push_back(e);
      end
      foreach (mq[i])
        if (mq[i].avail == cyc && mq[i].err && m_err < 255)
          m_err++;
    end
    @(negedge clk);
  endtask

  task automatic issue(input int r, input bit f,
                       input bit ordy);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      step(1'b1, r, f, ordy, 1'b1);
      done = last_acc;
    end
    if (!done)
      chk("issue_timeout", done, 1);
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int k = 0; k < n; k++)
      step(1'b0, int'($urandom_range(0, 255)),
           1'b0, ordy, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && mq.size() > 0; k++)
      idle(1, 1'b1);
    chk("drain_done", mq.size(), 0);
  endtask

  task automatic chk_zero_head();
    chk("rst_radicand", bus.out_radicand, 0);
    chk("rst_root", bus.out_root, 0);
    chk("rst_remainder", bus.out_remainder, 0);
    chk("rst_round", bus.out_round, 0);
    chk("rst_err", bus.out_err, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    cyc = 0;
    m_err = 0;
    rst_n = 1'b0;
    flt = 1'b0;
    bus.in_valid = 1'b0;
    bus.radicand = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_err_count", err_count, 0);
    chk_zero_head();

    issue(200, 1'b0, 1'b1);
    idle(8, 1'b1);

    issue(0, 1'b0, 1'b1);
    issue(1, 1'b0, 1'b1);
    issue(255, 1'b0, 1'b1);
    idle(8, 1'b1);

    issue(210, 1'b0, 1'b1);
    issue(211, 1'b0, 1'b1);
    idle(8, 1'b1);

    for (int k = 0; k < 10; k++)
      step(1'b1, int'($urandom_range(0, 255)),
           1'b0, 1'b0, 1'b1);
    drain();

    issue(99, 1'b0, 1'b1);
    issue(100, 1'b1, 1'b1);
    issue(101, 1'b0, 1'b1);
    idle(8, 1'b1);
    chk("err_one", err_count, 1);

    for (int k = 0; k < 300; k++)
      issue(int'($urandom_range(0, 255)), 1'b1, 1'b1);
    drain();
    chk("err_sat", err_count, 255);

    issue(50, 1'b0, 1'b0);
    issue(60, 1'b1, 1'b0);
    idle(6, 1'b0);
    issue(70, 1'b0, 1'b0);
    issue(80, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk_zero_head();
    idle(12, 1'b1);

    for (int k = 0; k < 1500; k++)
      step($urandom_range(0, 3) != 0,
           int'($urandom_range(0, 255)),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end
endmodule
